dm_copy: RTL and testbench

Memory-copy engine that drives the data-memory port as an initiator and moves a block of bytes from one data-memory region to another without CPU involvement. It issues read/write transactions on the same 10-bit-address, 32-bit-data, byte/word interface the CPU datapath uses. It also handles overlapping regions correctly (memmove semantics). It sits beside the CPU on the data-memory port; the CPU stalls on `busy`.

---
 rtl/dm_copy_pkg.sv | 31 +++
 rtl/dm_copy_if.sv | 29 ++
 rtl/dm_copy_step.sv | 88 ++++++++
 rtl/dm_copy.sv | 124 ++++++++++++
 tb/tb_dm_copy.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_copy_pkg.sv
// Shared types and constants for the data-memory copy engine.
package dm_copy_pkg;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LEN_W      = 11;
  localparam int unsigned SUM_W      = 12;
  localparam int unsigned MEM_BYTES  = 1024;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic              word_mode;
  } req_t;

  // True when the byte range [base, base+len) lies inside data memory.
  function automatic logic in_bounds(input logic [ADDR_W-1:0] base,
                                     input logic [LEN_W-1:0]  len);
    return (SUM_W'(base) + SUM_W'(len)) <= SUM_W'(MEM_BYTES);
  endfunction

endpackage

// File: rtl/dm_copy_if.sv
// Request/completion handshake plus data-memory initiator port of the copy engine.
interface dm_copy_if;
  import dm_copy_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic              word_mode;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic              mem_byte;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  start, src, dst, len, word_mode, mem_dout,
    output busy, done, err, mem_addr, mem_din, mem_we, mem_byte
  );

  modport master (
    output start, src, dst, len, word_mode, mem_dout,
    input  busy, done, err, mem_addr, mem_din, mem_we, mem_byte
  );

endinterface

// File: rtl/dm_copy_step.sv
// Pointer/count generator: plans words+tail bytes, picks direction, steps per write.
module dm_copy_step
  import dm_copy_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  req_t              req,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              is_byte,
  output logic              last
);

  localparam int unsigned WCNT_W = LEN_W - 2;
  // Backward steps are modular adds of (MEM_BYTES - k), i.e. subtract k.
  localparam logic [ADDR_W-1:0] FWD_BYTE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] FWD_WORD = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] BWD_BYTE = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] BWD_WORD = ADDR_W'(MEM_BYTES - WORD_BYTES);

  logic              backward_q;
  logic [WCNT_W-1:0] words_q;
  logic [LEN_W-1:0]  tail_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;

  logic              backward;
  logic [WCNT_W-1:0] words;
  logic [LEN_W-1:0]  tail;
  logic [SUM_W-1:0]  src_end;
  logic [SUM_W-1:0]  dst_end;
  logic [SUM_W-1:0]  back_off;
  logic [ADDR_W-1:0] delta;

  // Transfer plan and direction for the request presented at load.
  always_comb begin
    src_end  = SUM_W'(req.src) + SUM_W'(req.len);
    dst_end  = SUM_W'(req.dst) + SUM_W'(req.len);
    backward = (req.dst > req.src) && (SUM_W'(req.dst) < src_end);
    words    = req.word_mode ? WCNT_W'(req.len >> 2) : '0;
    tail     = req.len - {words, 2'b00};
    back_off = (tail != '0) ? SUM_W'(1) : SUM_W'(WORD_BYTES);
  end

  // Backward runs tail bytes first; the last tail byte hops down to the top word.
  always_comb begin
    is_byte = backward_q ? (tail_q != '0) : (words_q == '0);
    delta   = FWD_WORD;
    if (!backward_q) begin
      delta = is_byte ? FWD_BYTE : FWD_WORD;
    end else if (is_byte && (tail_q != LEN_W'(1))) begin
      delta = BWD_BYTE;
    end else begin
      delta = BWD_WORD;
    end
    last = (SUM_W'(words_q) + SUM_W'(tail_q)) == SUM_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      backward_q <= 1'b0;
      words_q    <= '0;
      tail_q     <= '0;
      src_q      <= '0;
      dst_q      <= '0;
    end else if (load) begin
      backward_q <= backward;
      words_q    <= words;
      tail_q     <= tail;
      src_q      <= backward ? ADDR_W'(src_end - back_off) : req.src;
      dst_q      <= backward ? ADDR_W'(dst_end - back_off) : req.dst;
    end else if (step) begin
      src_q <= src_q + delta;
      dst_q <= dst_q + delta;
      if (is_byte) begin
        tail_q <= tail_q - LEN_W'(1);
      end else begin
        words_q <= words_q - WCNT_W'(1);
      end
    end
  end

  assign src_addr = src_q;
  assign dst_addr = dst_q;

endmodule

// File: rtl/dm_copy.sv
// Data-memory copy engine (memmove semantics): one read then one write per transfer.
module dm_copy
  import dm_copy_pkg::*;
(
  input  logic clk,
  input  logic rst,
  dm_copy_if.slave bus
);

  state_t            state_q;
  state_t            state_nx;
  req_t              req;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              load;
  logic              zero_len;
  logic              reject;

  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic              is_byte;
  logic              last;

  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic              mem_byte;

  assign req      = '{src: bus.src, dst: bus.dst, len: bus.len, word_mode: bus.word_mode};
  assign zero_len = (bus.len == '0);
  assign reject   = !in_bounds(bus.src, bus.len) || !in_bounds(bus.dst, bus.len);
  assign load     = (state_q == IDLE) && bus.start;

  dm_copy_step u_step (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (state_q == WR),
    .req      (req),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .is_byte  (is_byte),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_nx = (zero_len || reject) ? DONE : RD;
        end
      end
      RD:      state_nx = WR;
      WR:      state_nx = last ? DONE : RD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read-data holding register and the latched rejection flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == RD) begin
        data_q <= bus.mem_dout;
      end
      if (load) begin
        err_q <= reject && !zero_len;
      end
    end
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    mem_byte = 1'b0;
    case (state_q)
      RD: begin
        busy     = 1'b1;
        mem_addr = src_addr;
        mem_byte = is_byte;
      end
      WR: begin
        busy     = 1'b1;
        mem_addr = dst_addr;
        mem_din  = data_q;
        mem_we   = 1'b1;
        mem_byte = is_byte;
      end
      DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_din  = mem_din;
  assign bus.mem_we   = mem_we;
  assign bus.mem_byte = mem_byte;

endmodule

// File: tb/tb_dm_copy.sv
// Self-checking bench for dm_copy: byte-array memory, memmove reference, directed + random copies.
module tb_dm_copy;
  import dm_copy_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_copy_if bus ();

  dm_copy dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  mem     [MEM_BYTES];
  logic [7:0]  img     [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        img_load;
  int          passes = 0;
  int          total = 0;
  int          wr_count = 0;
  int          done_cnt = 0;
  logic [10:0] wlog [$];

  // Memory read port: combinational, sign-extended for byte reads.
  always_comb begin
    logic [ADDR_W-1:0] a;
    a = bus.mem_addr;
    if (bus.mem_byte) begin
      bus.mem_dout = {{24{mem[a][7]}}, mem[a]};
    end else begin
      bus.mem_dout = {mem[a + ADDR_W'(3)], mem[a + ADDR_W'(2)], mem[a + ADDR_W'(1)], mem[a]};
    end
  end

  always @(posedge clk) begin
    if (img_load) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= img[i];
    end else if (bus.mem_we) begin
      wr_count++;
      wlog.push_back({bus.mem_byte, bus.mem_addr});
      if (bus.mem_byte) begin
        mem[bus.mem_addr] <= bus.mem_din[7:0];
      end else begin
        for (int k = 0; k < 4; k++) mem[bus.mem_addr + ADDR_W'(k)] <= bus.mem_din[8*k +: 8];
      end
    end
    if (bus.done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Push the reference image into the simulated memory (call at a negedge).
  task automatic sync_mem();
    for (int i = 0; i < MEM_BYTES; i++) img[i] = ref_mem[i];
    img_load = 1'b1;
    @(negedge clk);
    img_load = 1'b0;
  endtask

  // Launch one copy, update the reference with memmove, check timing/flags/memory.
  task automatic run_copy(input int s, input int d, input int l, input bit wm,
                          input bit poke, input string tag);
    int  n;
    int  busy_cyc;
    int  elapsed;
    int  w0;
    bit  exp_err;
    bit  got_done;
    logic [7:0] tmp [$];
    exp_err = (l != 0) && ((s + l > MEM_BYTES) || (d + l > MEM_BYTES));
    n = (l == 0 || exp_err) ? 0 : (wm ? (l / 4 + l % 4) : l);
    if (n > 0) begin
      for (int i = 0; i < l; i++) tmp.push_back(ref_mem[s + i]);
      for (int i = 0; i < l; i++) ref_mem[d + i] = tmp[i];
    end
    @(negedge clk);
    bus.src       = ADDR_W'(s);
    bus.dst       = ADDR_W'(d);
    bus.len       = LEN_W'(l);
    bus.word_mode = wm;
    bus.start     = 1'b1;
    w0 = wr_count;
    wlog.delete();
    @(negedge clk);
    bus.start = 1'b0;
    busy_cyc = 0;
    elapsed  = 0;
    got_done = 1'b0;
    for (int c = 0; c < 4000 && !got_done; c++) begin
      if (bus.done) begin
        got_done = 1'b1;
        chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, " err"}, 32'(bus.err), 32'(exp_err));
      end else begin
        elapsed++;
        if (bus.busy) busy_cyc++;
        if (poke && busy_cyc == 3) begin
          bus.start     = 1'b1;
          bus.src       = ADDR_W'(s + 7);
          bus.dst       = ADDR_W'(d + 3);
          bus.len       = LEN_W'(l + 5);
          bus.word_mode = ~wm;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    chk({tag, " done_seen"}, 32'(got_done), 32'd1);
    chk({tag, " cycles_to_done"}, 32'(elapsed), 32'(2 * n));
    chk({tag, " busy_cycles"}, 32'(busy_cyc), 32'(2 * n));
    chk({tag, " writes"}, 32'(wr_count - w0), 32'(n));
    chk({tag, " mem_diffs"}, 32'(mem_diffs()), 32'd0);
  endtask

  initial begin
    int d0;
    int w0;
    int s;
    int d;
    int l;
    int off;
    bit found;
    rst           = 1'b1;
    img_load      = 1'b0;
    bus.start     = 1'b0;
    bus.src       = '0;
    bus.dst       = '0;
    bus.len       = '0;
    bus.word_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst err", 32'(bus.err), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst mem_din", bus.mem_din, 32'd0);
    chk("rst mem_byte", 32'(bus.mem_byte), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
    sync_mem();

    for (int i = 0; i < 8; i++) ref_mem[i] = 8'(i);
    sync_mem();
    run_copy(0, 16, 8, 1'b1, 1'b0, "fwd_word");
    chk("fwd_word nlog", 32'(wlog.size()), 32'd2);
    chk("fwd_word w0", 32'(wlog[0]), {21'd0, 1'b0, 10'd16});
    chk("fwd_word w1", 32'(wlog[1]), {21'd0, 1'b0, 10'd20});

    ref_mem[100] = 8'h80; ref_mem[101] = 8'h81; ref_mem[102] = 8'h7F;
    ref_mem[103] = 8'h00; ref_mem[104] = 8'hFF;
    sync_mem();
    run_copy(100, 200, 5, 1'b0, 1'b0, "byte_odd");

    for (int i = 0; i < 10; i++) ref_mem[i] = 8'(i + 1);
    sync_mem();
    run_copy(0, 2, 10, 1'b1, 1'b0, "overlap");
    chk("overlap nlog", 32'(wlog.size()), 32'd4);
    chk("overlap w0", 32'(wlog[0]), {21'd0, 1'b1, 10'd11});
    chk("overlap w1", 32'(wlog[1]), {21'd0, 1'b1, 10'd10});
    chk("overlap w2", 32'(wlog[2]), {21'd0, 1'b0, 10'd6});
    chk("overlap w3", 32'(wlog[3]), {21'd0, 1'b0, 10'd2});

    run_copy(1020, 0, 8, 1'b1, 1'b0, "src_oob");
    run_copy(0, 1020, 8, 1'b1, 1'b0, "dst_oob");
    run_copy(0, 1016, 8, 1'b1, 1'b0, "dst_edge");
    run_copy(5, 6, 0, 1'b1, 1'b0, "zero_len");

    // Start presented during the DONE cycle must not launch a copy.
    run_copy(40, 60, 3, 1'b0, 1'b0, "pre_done");
    bus.src = 10'd0; bus.dst = 10'd300; bus.len = 11'd4; bus.word_mode = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_start busy", 32'(bus.busy), 32'd0);
    chk("done_start done", 32'(bus.done), 32'd0);

    // Reset at the start of the third word transfer of a 16-byte copy.
    for (int i = 0; i < 8; i++) ref_mem[512 + i] = ref_mem[i];
    @(negedge clk);
    bus.src = 10'd0; bus.dst = 10'd512; bus.len = 11'd16; bus.word_mode = 1'b1;
    bus.start = 1'b1;
    w0 = wr_count;
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if ((wr_count - w0) == 2 && bus.busy && !bus.mem_we) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_mid reached", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid outputs", {bus.busy, bus.done, bus.err, bus.mem_we, bus.mem_byte,
                            bus.mem_addr, 17'(bus.mem_din)}, 32'd0);
    repeat (12) @(negedge clk);
    chk("rst_mid done_cnt", 32'(done_cnt - d0), 32'd0);
    chk("rst_mid writes", 32'(wr_count - w0), 32'd2);
    chk("rst_mid mem_diffs", 32'(mem_diffs()), 32'd0);

    d0 = done_cnt;
    run_copy(300, 400, 12, 1'b1, 1'b1, "ign_start");
    repeat (3) @(negedge clk);
    chk("ign_start single_done", 32'(done_cnt - d0), 32'd1);
    chk("ign_start idle", 32'(bus.busy), 32'd0);

    // Randomized back-to-back copies, many overlapping in either direction.
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
    sync_mem();
    for (int t = 0; t < 10; t++) begin
      s = $urandom_range(0, 960);
      l = $urandom_range(1, 60);
      if ($urandom_range(0, 1) == 1) begin
        off = $urandom_range(0, 16) - 8;
        d = s + off;
        if (d < 0) d = 0;
        if (d > 960) d = 960;
      end else begin
        d = $urandom_range(0, 960);
      end
      run_copy(s, d, l, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
